// File: rtl/flappy_screen_compositor.sv
// Frame compositor for the red/green LED matrix: merges the bird column and
// the pipe field into colour planes, runs the idle/run/pause/over sequence,
// detects bird/pipe collisions and blinks an end-screen bitmap after game over.
module flappy_screen_compositor #(
    parameter int                   COLS         = 16,
    parameter int                   ROWS         = 16,
    parameter int                   BIRD_COL     = 2,
    parameter int                   BLINK_PERIOD = 25_000_000,
    parameter logic [COLS*ROWS-1:0] END_PATTERN  = '1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       kill,
    input  logic [ROWS-1:0]            bird_in,
    input  logic [COLS-1:0][ROWS-1:0]  pipe_in,
    output logic [COLS-1:0][ROWS-1:0]  red_out,
    output logic [COLS-1:0][ROWS-1:0]  green_out,
    output logic [1:0]                 state_out,
    output logic                       collision
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int              CNT_W    = $clog2(BLINK_PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_PERIOD - 1);

    state_t                    state, ns;
    logic                      start_q;
    logic                      start_rise;
    logic                      hit;
    logic [CNT_W-1:0]          blink_cnt, blink_cnt_nx;
    logic                      blink_phase, blink_phase_nx;
    logic [COLS-1:0][ROWS-1:0] bird_frame;
    logic [COLS-1:0][ROWS-1:0] red_nx, green_nx;

    assign start_rise = start & ~start_q;
    assign hit        = |(bird_in & pipe_in[BIRD_COL]);
    assign state_out  = state;

    // Place the bird column into an otherwise empty frame.
    always_comb begin
        bird_frame           = '0;
        bird_frame[BIRD_COL] = bird_in;
    end

    // Game sequence next-state; kill/hit outrank pause, start only acts on a fresh edge.
    always_comb begin
        ns = state;
        case (state)
            IDLE:    if (start_rise) ns = RUN;
            RUN: begin
                if (kill || hit) ns = OVER;
                else if (pause)  ns = PAUSE;
            end
            PAUSE: begin
                if (kill)        ns = OVER;
                else if (!pause) ns = RUN;
            end
            OVER:    if (start_rise) ns = IDLE;
            default: ns = IDLE;
        endcase
    end

    // Blink timer: restart lit on entry to OVER, toggle every BLINK_PERIOD cycles while there.
    always_comb begin
        blink_cnt_nx   = blink_cnt;
        blink_phase_nx = blink_phase;
        if (ns == OVER) begin
            if (state != OVER) begin
                blink_cnt_nx   = '0;
                blink_phase_nx = 1'b1;
            end else if (blink_cnt == CNT_LAST) begin
                blink_cnt_nx   = '0;
                blink_phase_nx = ~blink_phase;
            end else begin
                blink_cnt_nx   = blink_cnt + CNT_W'(1);
            end
        end
    end

    // Frame content follows the state being entered; PAUSE freezes the display.
    always_comb begin
        red_nx   = red_out;
        green_nx = green_out;
        case (ns)
            IDLE: begin
                red_nx   = bird_frame;
                green_nx = '0;
            end
            RUN: begin
                red_nx   = bird_frame;
                green_nx = pipe_in;
            end
            OVER: begin
                red_nx   = blink_phase_nx ? END_PATTERN : '0;
                green_nx = '0;
            end
            default: ;
        endcase
    end

    // Register state, frames, blink timer and the sticky collision flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            red_out     <= '0;
            green_out   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            collision   <= 1'b0;
        end else begin
            state       <= ns;
            start_q     <= start;
            red_out     <= red_nx;
            green_out   <= green_nx;
            blink_cnt   <= blink_cnt_nx;
            blink_phase <= blink_phase_nx;
            if (state == RUN && ns == OVER && hit)
                collision <= 1'b1;
            else if (state == OVER && ns == IDLE)
                collision <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flappy_screen_compositor.sv
// Directed-plus-random bench for flappy_screen_compositor with a behavioural
// reference model of the game sequence, frame content and blink schedule.
module tb_flappy_screen_compositor;

    localparam int COLS = 16;
    localparam int ROWS = 16;
    localparam int BCOL = 2;
    localparam int BP   = 4;
    localparam logic [COLS*ROWS-1:0] PAT = {16{16'h1234}} ^ {8{32'h00FF_F00F}};

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      start = 1'b0;
    logic                      pause = 1'b0;
    logic                      kill = 1'b0;
    logic [ROWS-1:0]           bird_in = '0;
    logic [COLS-1:0][ROWS-1:0] pipe_in = '0;
    logic [COLS-1:0][ROWS-1:0] red_out;
    logic [COLS-1:0][ROWS-1:0] green_out;
    logic [1:0]                state_out;
    logic                      collision;

    int compared = 0;
    int mismatched = 0;

    // reference model state (0 idle, 1 run, 2 pause, 3 over)
    int                        m_st = 0;
    bit                        m_start_q = 0;
    int                        m_over_k = 0;
    bit                        m_coll = 0;
    logic [COLS-1:0][ROWS-1:0] m_red = '0;
    logic [COLS-1:0][ROWS-1:0] m_green = '0;

    flappy_screen_compositor #(
        .COLS(COLS), .ROWS(ROWS), .BIRD_COL(BCOL),
        .BLINK_PERIOD(BP), .END_PATTERN(PAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .kill(kill),
        .bird_in(bird_in), .pipe_in(pipe_in), .red_out(red_out),
        .green_out(green_out), .state_out(state_out), .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge from the currently driven inputs.
    task automatic model_step();
        bit hit, rise;
        int nxt;
        hit  = |(bird_in & pipe_in[BCOL]);
        rise = start && !m_start_q;
        if (reset) begin
            m_st = 0; m_start_q = 0; m_coll = 0; m_red = '0; m_green = '0; m_over_k = 0;
            return;
        end
        nxt = m_st;
        if (m_st == 0 && rise) nxt = 1;
        else if (m_st == 1) begin
            if (kill || hit) nxt = 3;
            else if (pause) nxt = 2;
        end else if (m_st == 2) begin
            if (kill) nxt = 3;
            else if (!pause) nxt = 1;
        end else if (m_st == 3 && rise) nxt = 0;

        if (m_st == 1 && nxt == 3 && hit) m_coll = 1;
        if (m_st == 3 && nxt == 0) m_coll = 0;

        if (nxt == 3) begin
            m_over_k = (m_st == 3) ? m_over_k + 1 : 0;
            m_red    = (((m_over_k / BP) % 2) == 0) ? PAT : '0;
            m_green  = '0;
        end else if (nxt != 2) begin
            m_red = '0;
            m_red[BCOL] = bird_in;
            m_green = (nxt == 1) ? pipe_in : '0;
        end
        m_st = nxt;
        m_start_q = start;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("state_out", 256'(state_out), 256'(m_st));
        chk("collision", 256'(collision), 256'(m_coll));
        chk("red_out", red_out, m_red);
        chk("green_out", green_out, m_green);
    endtask

    task automatic rand_pipe(input bit allow_hit);
        for (int c = 0; c < COLS; c++) pipe_in[c] = ROWS'($urandom);
        if (!allow_hit) pipe_in[BCOL] = pipe_in[BCOL] & ~bird_in;
    endtask

    task automatic rand_bird();
        bird_in = ROWS'(1) << $urandom_range(ROWS - 1, 0);
    endtask

    initial begin
        // reset state
        tick(); tick();

        // idle frame then start edge into RUN
        reset = 1'b0;
        bird_in = 16'h0010;
        rand_pipe(0);
        tick();
        start = 1'b1; tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin rand_bird(); rand_pipe(0); tick(); end

        // pause with changing pipes, including overlaps that must be ignored
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_bird(); rand_pipe(1);
            if (i % 3 == 0) pipe_in[BCOL] = bird_in;
            tick();
        end
        pause = 1'b0;
        rand_bird(); rand_pipe(0); tick(); tick();

        // collision into OVER, blink for three half-periods, inputs ignored
        bird_in = 16'h0020; rand_pipe(1); pipe_in[BCOL] = 16'h00F0;
        tick();
        for (int i = 0; i < 12; i++) begin
            kill = 1'($urandom); pause = 1'($urandom); rand_bird(); rand_pipe(1); tick();
        end
        kill = 1'b0; pause = 1'b0;

        // start held high through OVER->IDLE must not re-enter RUN
        start = 1'b1; rand_pipe(0); tick();
        tick(); tick(); tick();
        start = 1'b0; tick();
        start = 1'b1; tick();
        start = 1'b0; tick();

        // kill and pause together in RUN: OVER without collision
        kill = 1'b1; pause = 1'b1; tick();
        kill = 1'b0; pause = 1'b0; tick(); tick();
        start = 1'b1; tick();
        start = 1'b0; tick();
        start = 1'b1; tick();
        start = 1'b0; rand_bird(); rand_pipe(0); tick();

        // hit and kill in the same cycle, then reset mid-OVER
        kill = 1'b1; pipe_in[BCOL] = bird_in; tick();
        kill = 1'b0; tick(); tick();
        reset = 1'b1; tick();
        reset = 1'b0; tick();

        // randomized play against the model
        for (int i = 0; i < 300; i++) begin
            start = ($urandom_range(7, 0) == 0);
            pause = ($urandom_range(9, 0) == 0) ? ~pause : pause;
            kill  = ($urandom_range(29, 0) == 0);
            reset = ($urandom_range(99, 0) == 0);
            rand_bird();
            rand_pipe($urandom_range(19, 0) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
